// File: rtl/bus_transfer_ctrl.sv
// bus_transfer_ctrl
// Source-side sequencer for the 16-bit datapath bus. Takes one transfer
// request at a time (register or immediate source, register destination),
// drives the bus from the chosen source and pulses the destination's
// one-hot load enable, then reports completion (done) or rejection (err).
// Optional feature: define XFER_SWAP_EN to add the two-register swap
// sequence (SETUP_S -> SAVE -> LOAD_A -> LOAD_B -> DONE).
module bus_transfer_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  swap,
  input  logic [3:0]            src,
  input  logic [2:0]            dst,
  input  logic [WIDTH-1:0]      din,
  input  logic [NREG*WIDTH-1:0] rout_all,
  output logic [WIDTH-1:0]      buswires,
  output logic [NREG-1:0]       rin_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Source code 8 selects the latched immediate; anything above is invalid.
  localparam logic [3:0] SRC_IMM = 4'd8;

`ifdef XFER_SWAP_EN
  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_DONE,
    S_ERR,
    S_SETUP_S,
    S_SAVE,
    S_LOAD_A,
    S_LOAD_B
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;
`endif

  state_t           r_state;
  logic [3:0]       r_src;
  logic [2:0]       r_dst;
  logic [WIDTH-1:0] r_imm;
  logic [NREG-1:0]  r_rin_en;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
`ifdef XFER_SWAP_EN
  // Holds R[dst] across the swap so it can be written back into R[src].
  logic [WIDTH-1:0] r_temp;
`endif

  logic [WIDTH-1:0] w_regs [NREG];
  logic [WIDTH-1:0] w_bus;
  logic             w_reject;

`ifndef XFER_SWAP_EN
  // Without the swap feature the swap select has no effect on the sequence.
  logic w_unused_swap;
  assign w_unused_swap = swap;
`endif

  // One-hot load-enable for a register index.
  function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Split the flat register-file bus into per-register words.
  for (genvar k = 0; k < NREG; k++) begin : g_unpack
    assign w_regs[k] = rout_all[k*WIDTH +: WIDTH];
  end

  // Requests that are turned away with err instead of starting a transfer.
`ifdef XFER_SWAP_EN
  assign w_reject = (src > SRC_IMM) || (swap && (src == SRC_IMM));
`else
  assign w_reject = (src > SRC_IMM);
`endif

  // Bus source mux: follows the live register outputs so the destination
  // captures whatever the source holds at the load edge; zero when idle.
  always_comb begin
    w_bus = '0;
    case (r_state)
      S_SETUP,
      S_LOAD:    w_bus = r_src[3] ? r_imm : w_regs[r_src[2:0]];
`ifdef XFER_SWAP_EN
      S_SETUP_S,
      S_SAVE:    w_bus = w_regs[r_dst];
      S_LOAD_A:  w_bus = w_regs[r_src[2:0]];
      S_LOAD_B:  w_bus = r_temp;
`endif
      default:   w_bus = '0;
    endcase
  end

  // Transfer sequencer; control outputs are registered for the state entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_imm    <= '0;
      r_rin_en <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef XFER_SWAP_EN
      r_temp   <= '0;
`endif
    end else begin
      r_rin_en <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_src <= src;
            r_dst <= dst;
            r_imm <= din;
            if (w_reject) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
`ifdef XFER_SWAP_EN
            else if (swap) begin
              r_state <= S_SETUP_S;
              r_busy  <= 1'b1;
            end
`endif
            else begin
              r_state <= S_SETUP;
              r_busy  <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          r_state  <= S_LOAD;
          r_busy   <= 1'b1;
          r_rin_en <= onehot(r_dst);
        end
        S_LOAD: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
`ifdef XFER_SWAP_EN
        S_SETUP_S: begin
          r_state <= S_SAVE;
          r_busy  <= 1'b1;
        end
        S_SAVE: begin
          r_temp   <= w_bus;
          r_state  <= S_LOAD_A;
          r_busy   <= 1'b1;
          r_rin_en <= onehot(r_dst);
        end
        S_LOAD_A: begin
          r_state  <= S_LOAD_B;
          r_busy   <= 1'b1;
          r_rin_en <= onehot(r_src[2:0]);
        end
        S_LOAD_B: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign buswires = w_bus;
  assign rin_en   = r_rin_en;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Testbench for bus_transfer_ctrl: table-driven vectors, hand-written corner
// sequences and randomized transfers against a transaction-level model.
`timescale 1ns/1ps
module tb_bus_transfer_ctrl;

`ifdef XFER_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         req;
  logic         swap;
  logic [3:0]   src;
  logic [2:0]   dst;
  logic [15:0]  din;
  logic [127:0] rout_all;
  logic [15:0]  buswires;
  logic [7:0]   rin_en;
  logic         busy;
  logic         done;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  // Register file attached to the bus, plus a bench-side preload port.
  logic [15:0] regs    [8];
  logic [15:0] tb_vals [8];
  logic        tb_ld = 1'b0;
  // Model's view of the register file.
  logic [15:0] mregs   [8];

  typedef struct {
    logic [15:0] bus;
    bit          chk_bus;
    logic [7:0]  rin;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  typedef struct {
    bit          sw;
    logic [3:0]  s;
    logic [2:0]  d;
    logic [15:0] imm;
    bit          exp_err;
    int          exp_len;
    logic [15:0] exp_val;
  } vec_t;

  exp_t expq [$];
  vec_t vecs [$];

  localparam exp_t IDLE_E = '{bus: 16'h0, chk_bus: 1'b1, rin: 8'h0, busy: 1'b0, done: 1'b0, err: 1'b0};

  always #5 clock = ~clock;

  bus_transfer_ctrl #(.WIDTH(16), .NREG(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .swap     (swap),
    .src      (src),
    .dst      (dst),
    .din      (din),
    .rout_all (rout_all),
    .buswires (buswires),
    .rin_en   (rin_en),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  for (genvar k = 0; k < 8; k++) begin : g_pack
    assign rout_all[k*16 +: 16] = regs[k];
  end

  always @(posedge clock) begin
    for (int k = 0; k < 8; k++) begin
      if (tb_ld)          regs[k] <= tb_vals[k];
      else if (rin_en[k]) regs[k] <= buswires;
    end
  end

  task automatic check_cycle(input string name, input exp_t e);
    logic [15:0] gb;
    gb = e.chk_bus ? buswires : e.bus;
    n_checks++;
    if (gb !== e.bus || rin_en !== e.rin || busy !== e.busy || done !== e.done || err !== e.err) begin
      n_errors++;
      $display("FAIL %s: got bus=%h rin_en=%h busy=%b done=%b err=%b, want bus=%h%s rin_en=%h busy=%b done=%b err=%b",
               name, buswires, rin_en, busy, done, err, e.bus, e.chk_bus ? "" : "(any)",
               e.rin, e.busy, e.done, e.err);
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_regs(input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < 8; k++) if (regs[k] !== mregs[k]) bad = bad + 1;
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL %s: register file got %h %h %h %h %h %h %h %h, want %h %h %h %h %h %h %h %h", name,
               regs[0], regs[1], regs[2], regs[3], regs[4], regs[5], regs[6], regs[7],
               mregs[0], mregs[1], mregs[2], mregs[3], mregs[4], mregs[5], mregs[6], mregs[7]);
    end
  endtask

  // Called at a negedge with req low; registers load at the next edge.
  task automatic load_regs();
    tb_ld = 1'b1;
    for (int k = 0; k < 8; k++) mregs[k] = tb_vals[k];
    @(negedge clock);
    tb_ld = 1'b0;
  endtask

  task automatic preset_init();
    for (int k = 0; k < 8; k++) tb_vals[k] = 16'(16'h1111 * (k + 1));
    load_regs();
  endtask

  task automatic preset_random();
    for (int k = 0; k < 8; k++) tb_vals[k] = 16'($urandom);
    load_regs();
  endtask

  // Transaction model: expected per-cycle outputs after acceptance and the
  // resulting register file contents.
  task automatic model_txn(input bit sw, input logic [3:0] s, input logic [2:0] d, input logic [15:0] imm);
    logic [15:0] v;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  oh_d;
    logic [7:0]  oh_s;
    bit          is_swap;
    expq.delete();
    is_swap = SWAP_EN && sw;
    oh_d = 8'd1 << d;
    oh_s = 8'd1 << s[2:0];
    if (s > 4'd8 || (is_swap && s == 4'd8)) begin
      expq.push_back('{bus: 16'h0, chk_bus: 1'b0, rin: 8'h0, busy: 1'b0, done: 1'b0, err: 1'b1});
    end else if (is_swap) begin
      a = mregs[s[2:0]];
      b = mregs[d];
      expq.push_back('{bus: b, chk_bus: 1'b1, rin: 8'h0, busy: 1'b1, done: 1'b0, err: 1'b0});
      expq.push_back('{bus: b, chk_bus: 1'b1, rin: 8'h0, busy: 1'b1, done: 1'b0, err: 1'b0});
      expq.push_back('{bus: a, chk_bus: 1'b1, rin: oh_d, busy: 1'b1, done: 1'b0, err: 1'b0});
      expq.push_back('{bus: b, chk_bus: 1'b1, rin: oh_s, busy: 1'b1, done: 1'b0, err: 1'b0});
      expq.push_back('{bus: 16'h0, chk_bus: 1'b1, rin: 8'h0, busy: 1'b0, done: 1'b1, err: 1'b0});
      mregs[d]      = a;
      mregs[s[2:0]] = b;
    end else begin
      v = (s == 4'd8) ? imm : mregs[s[2:0]];
      expq.push_back('{bus: v, chk_bus: 1'b1, rin: 8'h0, busy: 1'b1, done: 1'b0, err: 1'b0});
      expq.push_back('{bus: v, chk_bus: 1'b1, rin: oh_d, busy: 1'b1, done: 1'b0, err: 1'b0});
      expq.push_back('{bus: 16'h0, chk_bus: 1'b1, rin: 8'h0, busy: 1'b0, done: 1'b1, err: 1'b0});
      mregs[d] = v;
    end
  endtask

  // Issue one request at a negedge, check every busy cycle and the return to
  // idle. While busy the inputs are scrambled (hammer forces req high).
  task automatic run_txn(input bit sw, input logic [3:0] s, input logic [2:0] d, input logic [15:0] imm,
                         input string name, input bit hammer, output int lat, output bit saw_err);
    model_txn(sw, s, d, imm);
    lat     = -1;
    saw_err = 1'b0;
    req = 1'b1; swap = sw; src = s; dst = d; din = imm;
    @(posedge clock);
    for (int i = 0; i < expq.size(); i++) begin
      @(negedge clock);
      check_cycle($sformatf("%s_c%0d", name, i), expq[i]);
      if ((done === 1'b1 || err === 1'b1) && lat < 0) begin
        lat     = i + 1;
        saw_err = (err === 1'b1);
      end
      req  = hammer ? 1'b1 : 1'($urandom_range(0, 1));
      swap = 1'($urandom);
      src  = 4'($urandom);
      dst  = 3'($urandom);
      din  = 16'($urandom);
    end
    @(negedge clock);
    req = 1'b0;
    check_cycle($sformatf("%s_idle", name), IDLE_E);
  endtask

  initial begin
    int lat;
    bit se;
    exp_t e;

    // Reset held with a pending request: nothing may start.
    for (int k = 0; k < 8; k++) tb_vals[k] = 16'(16'h1111 * (k + 1));
    for (int k = 0; k < 8; k++) mregs[k] = tb_vals[k];
    tb_ld = 1'b1;
    reset = 1'b1; req = 1'b1; swap = 1'b0; src = 4'd3; dst = 3'd2; din = 16'h5A5A;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      tb_ld = 1'b0;
      check_cycle($sformatf("reset_hold%0d", i), IDLE_E);
    end
    reset = 1'b0; req = 1'b0;
    @(negedge clock);
    check_cycle("post_reset_idle", IDLE_E);
    check_regs("post_reset_regs");

    // Table of single transfers; registers start at R_k = 1111*(k+1).
    vecs.push_back('{sw: 0, s: 4'd2,  d: 3'd5, imm: 16'h0000, exp_err: 0, exp_len: 3, exp_val: 16'h3333});
    vecs.push_back('{sw: 0, s: 4'd8,  d: 3'd0, imm: 16'hBEEF, exp_err: 0, exp_len: 3, exp_val: 16'hBEEF});
    vecs.push_back('{sw: 0, s: 4'd7,  d: 3'd7, imm: 16'h0000, exp_err: 0, exp_len: 3, exp_val: 16'h8888});
    vecs.push_back('{sw: 0, s: 4'd0,  d: 3'd3, imm: 16'hFFFF, exp_err: 0, exp_len: 3, exp_val: 16'h1111});
    vecs.push_back('{sw: 0, s: 4'd9,  d: 3'd1, imm: 16'h1234, exp_err: 1, exp_len: 1, exp_val: 16'h2222});
    vecs.push_back('{sw: 0, s: 4'd15, d: 3'd4, imm: 16'h1234, exp_err: 1, exp_len: 1, exp_val: 16'h5555});
    vecs.push_back('{sw: 0, s: 4'd5,  d: 3'd6, imm: 16'h0000, exp_err: 0, exp_len: 3, exp_val: 16'h6666});
`ifdef XFER_SWAP_EN
    vecs.push_back('{sw: 1, s: 4'd8,  d: 3'd2, imm: 16'h1234, exp_err: 1, exp_len: 1, exp_val: 16'h3333});
    vecs.push_back('{sw: 1, s: 4'd1,  d: 3'd6, imm: 16'h0000, exp_err: 0, exp_len: 5, exp_val: 16'h2222});
    vecs.push_back('{sw: 1, s: 4'd3,  d: 3'd3, imm: 16'h0000, exp_err: 0, exp_len: 5, exp_val: 16'h4444});
`else
    vecs.push_back('{sw: 1, s: 4'd8,  d: 3'd2, imm: 16'h1234, exp_err: 0, exp_len: 3, exp_val: 16'h1234});
    vecs.push_back('{sw: 1, s: 4'd1,  d: 3'd6, imm: 16'h0000, exp_err: 0, exp_len: 3, exp_val: 16'h2222});
`endif
    foreach (vecs[i]) begin
      preset_init();
      run_txn(vecs[i].sw, vecs[i].s, vecs[i].d, vecs[i].imm, $sformatf("vec%0d", i), 1'b0, lat, se);
      check_eq($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_len));
      check_eq($sformatf("vec%0d_err", i), 32'(se), 32'(vecs[i].exp_err));
      check_eq($sformatf("vec%0d_dstval", i), 32'(regs[vecs[i].d]), 32'(vecs[i].exp_val));
      check_regs($sformatf("vec%0d_regs", i));
    end

    // Immediate is latched: changing din after acceptance has no effect.
    preset_init();
    req = 1'b1; swap = 1'b0; src = 4'd8; dst = 3'd0; din = 16'hBBBB;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0; din = 16'hCCCC;
    e = '{bus: 16'hBBBB, chk_bus: 1'b1, rin: 8'h00, busy: 1'b1, done: 1'b0, err: 1'b0};
    check_cycle("imm_setup", e);
    @(negedge clock);
    e = '{bus: 16'hBBBB, chk_bus: 1'b1, rin: 8'h01, busy: 1'b1, done: 1'b0, err: 1'b0};
    check_cycle("imm_load", e);
    @(negedge clock);
    e = '{bus: 16'h0000, chk_bus: 1'b1, rin: 8'h00, busy: 1'b0, done: 1'b1, err: 1'b0};
    check_cycle("imm_done", e);
    @(negedge clock);
    check_cycle("imm_idle", IDLE_E);
    check_eq("imm_r0", 32'(regs[0]), 32'h0000BBBB);

    // Requests held high while busy are ignored (error and move).
    preset_init();
    run_txn(1'b0, 4'd12, 3'd3, 16'h0000, "err_hammer", 1'b1, lat, se);
    check_eq("err_hammer_latency", 32'(lat), 32'd1);
    @(negedge clock);
    check_cycle("err_hammer_quiet", IDLE_E);
    check_regs("err_hammer_regs");
    run_txn(1'b0, 4'd2, 3'd5, 16'h0000, "move_hammer", 1'b1, lat, se);
    @(negedge clock);
    check_cycle("move_hammer_quiet", IDLE_E);
    check_regs("move_hammer_regs");

    // Reset during SETUP aborts with no load and no completion.
    preset_init();
    req = 1'b1; swap = 1'b0; src = 4'd2; dst = 3'd5; din = 16'h0000;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0; reset = 1'b1;
    e = '{bus: 16'h3333, chk_bus: 1'b1, rin: 8'h00, busy: 1'b1, done: 1'b0, err: 1'b0};
    check_cycle("abort_setup", e);
    @(negedge clock);
    reset = 1'b0;
    check_cycle("abort_reset", IDLE_E);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_cycle($sformatf("abort_after%0d", i), IDLE_E);
    end
    check_regs("abort_regs");

`ifdef XFER_SWAP_EN
    // Swap R1/R6: LOAD_A writes R6 from R1, LOAD_B writes R1 from temp.
    for (int k = 0; k < 8; k++) tb_vals[k] = 16'h0000;
    tb_vals[1] = 16'h1111;
    tb_vals[6] = 16'h6666;
    load_regs();
    run_txn(1'b1, 4'd1, 3'd6, 16'h0000, "swap16", 1'b0, lat, se);
    check_eq("swap16_latency", 32'(lat), 32'd5);
    check_eq("swap16_r1", 32'(regs[1]), 32'h00006666);
    check_eq("swap16_r6", 32'(regs[6]), 32'h00001111);
`endif

    // Randomized transfers against the model.
    for (int t = 0; t < 80; t++) begin
      if (t % 8 == 0) preset_random();
      run_txn(1'($urandom), 4'($urandom), 3'($urandom), 16'($urandom),
              $sformatf("rnd%0d", t), 1'($urandom), lat, se);
      check_regs($sformatf("rnd%0d_regs", t));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_transfer_ctrl.md
# bus_transfer_ctrl

- Sequencing source side of the simple CPU's 16-bit datapath bus.
- Accepts one move request at a time: source is one of eight general registers or an immediate; destination is one register.
- Drives `buswires` from the selected source and pulses the matching one-hot `rin_en` bit, so the destination `register_16bit` captures the value.
- Sits between the control decoder and the register file; reports completion with `done`, or rejection with `err`.

## Interface
Parameters:
- `WIDTH`, 16, data/bus width
- `NREG`, 8, number of general registers (fixed at 8; `dst` is 3 bits)

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req`  in  1  transfer request, sampled only in IDLE
- `swap`  in  1  swap operation select (see Configuration)
- `src`  in  4  source: 0–7 = register Rk, 8 = immediate `din`, 9–15 = invalid
- `dst`  in  3  destination register index
- `din`  in  WIDTH  immediate data
- `rout_all`  in  NREG*WIDTH  register outputs; Rk is at bits [16k+15:16k]
- `buswires`  out  WIDTH  bus value
- `rin_en`  out  NREG  one-hot register load enables
- `busy`  out  1  high while a transfer is in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle rejection pulse

## Operation
- Reset behaviour: state goes to IDLE and all outputs clear: `buswires`=0, `rin_en`=0, `busy`=0, `done`=0, `err`=0. The internal `src`/`dst`/immediate/temp latches also clear.
- IDLE:
  - Bus drives 0.
  - On `req`=1, the unit latches `src`, `dst`, `swap`, and `din`.
  - If `src`≥9, or `swap`=1 with `src`=8: go to ERR.
  - Otherwise, for a move: go to SETUP.
- SETUP:
  - Bus = source (live Rk, or the latched immediate). `rin_en`=0. `busy`=1.
  - Next state is LOAD.
- LOAD:
  - Bus = source. `rin_en[dst]`=1. `busy`=1.
  - Next state is DONE.
- DONE: `done`=1, `busy`=0, bus=0, `rin_en`=0. Next state is IDLE.
- ERR: `err`=1, `busy`=0, no `rin_en`. Next state is IDLE.
- `req` is ignored outside IDLE. Requests are not queued.
- Outside LOAD, or the swap load states, `rin_en` is all zero. At most one bit is ever set.
- Move with `src`==`dst` is legal: the register reloads its own value.

## Timing
- `req` sampled high at edge N:
  - SETUP occupies cycle N..N+1.
  - LOAD occupies N+1..N+2; the destination captures at edge N+2.
  - `done` is high in cycle N+2..N+3.
  - IDLE at N+3. The next `req` is accepted at edge N+3.
- Move occupancy: 3 cycles. Error occupancy: 1 cycle, with `err` high in cycle N..N+1.
- Bus value is stable for the full cycle before and the full cycle of the `rin_en` edge, giving one setup cycle.
- Reset asserted mid-transfer takes effect at the next edge. No `rin_en` is asserted after that edge, and neither `done` nor `err` is emitted for the aborted transfer.

## Configuration
- `XFER_SWAP_EN`, when defined, adds the swap operation. A request with `swap`=1 and valid register `src` runs this sequence:
  - SETUP_S: bus=R[dst].
  - SAVE: bus=R[dst]; temp captures the bus at the end of the cycle.
  - LOAD_A: bus=R[src], `rin_en[dst]`=1.
  - LOAD_B: bus=temp, `rin_en[src]`=1.
  - DONE.
- Swap occupancy is 5 cycles. With `src`==`dst`, the register is unchanged and `done` is still pulsed.
- Without `XFER_SWAP_EN`:
  - The `swap` input is ignored; every valid request is a move.
  - The temp register and swap states are not built.
  - `src`=8 with `swap`=1 performs an immediate move, not an error.

## Test plan
- Reset with `req`=1, `src`=3: all outputs 0 for the whole reset period and no transfer starts. After release, a `req` performs a normal move.
- R2=16'hAAAA, `req` with `src`=2, `dst`=5:
  - `buswires`=16'hAAAA for 2 cycles.
  - `rin_en`=8'h20 for exactly 1 cycle.
  - `done` pulses 3 cycles after acceptance.
- Immediate move, `src`=8, `din`=16'hBBBB, `dst`=0:
  - `din` is changed to 16'hCCCC one cycle after acceptance.
  - Bus still shows 16'hBBBB and `rin_en`=8'h01.
- `src`=12: `err` pulses one cycle later; `rin_en` is never set and `done` is never set. A `req` during SETUP/LOAD is ignored and produces no second `done`.
- Reset asserted in the SETUP cycle: `rin_en` stays 0, no `done`, state returns to IDLE.
- With `XFER_SWAP_EN`, R1=16'h1111, R6=16'h6666, swap `src`=1, `dst`=6:
  - LOAD_A has bus 16'h1111 and `rin_en`=8'h40.
  - LOAD_B has bus 16'h6666 and `rin_en`=8'h02.
  - `done` pulses 5 cycles after acceptance.
